// File: rtl/pcie_tx_inject.sv
`default_nettype none
// ============================================================================
// pcie_tx_inject : releases fully committed TLPs from the TX TLP FIFO onto the
//                  64-bit 7-series PCIe AXI4-Stream transmit interface.
// Revision 1.0
// ============================================================================
module pcie_tx_inject #(
  parameter int CNT_W = 8
) (
  input  logic         pcie_clk,
  input  logic         pcie_rst_n,
  input  logic         pkt_commit,
  output logic         rd_en,
  input  logic [73:0]  dout,
  input  logic         empty,
  output logic         s_axis_tx_tvalid,
  input  logic         s_axis_tx_tready,
  output logic         s_axis_tx_tlast,
  output logic [7:0]   s_axis_tx_tkeep,
  output logic [63:0]  s_axis_tx_tdata,
  output logic [3:0]   s_axis_tx_tuser,
  output logic [31:0]  tx_pkt_count,
  output logic [15:0]  tx_dsc_count,
  output logic         err_underrun,
  output logic         err_cnt_ovf
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_XFER  = 1'b1;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] PEND_ZERO = '0;
  localparam logic [31:0]      PKT_ONE  = 32'd1;
  localparam logic [15:0]      DSC_ONE  = 16'd1;
  localparam logic [15:0]      DSC_MAX  = 16'hFFFF;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             sop_q, sop_d;
  logic             tvalid_q, tlast_q, dsc_q;
  logic [7:0]       tkeep_q;
  logic [63:0]      tdata_q;
  logic [31:0]      pkt_cnt_q;
  logic [15:0]      dsc_cnt_q;
  logic             underrun_q, ovf_q;

  logic w_word_vld, w_word_last, w_marker;
  logic w_slot_free, w_pop, w_pop_last, w_drop, w_load;
  logic w_norm_done;

  assign w_word_vld  = dout[73];
  assign w_word_last = dout[72];
  assign w_marker    = !w_word_vld && w_word_last;

  assign w_slot_free = !tvalid_q || s_axis_tx_tready;
  assign w_pop       = (state_q == ST_XFER) && !empty && w_slot_free;
  assign w_pop_last  = w_pop && w_word_last;
  // A truncation marker at the head of a packet carries no payload: nothing to emit.
  assign w_drop      = w_pop && w_marker && sop_q;
  assign w_load      = w_pop && !w_drop;
  assign w_norm_done = tvalid_q && s_axis_tx_tready && tlast_q && !dsc_q;

  always_comb begin
    pend_d = pend_q;
    if (pkt_commit && !w_pop_last) begin
      if (pend_q != PEND_MAX) begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (!pkt_commit && w_pop_last) begin
      pend_d = pend_q - PEND_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != PEND_ZERO) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (w_pop_last && (pend_d == PEND_ZERO)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sop_d = sop_q;
    if (w_pop) begin
      sop_d = w_word_last;
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      sop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sop_q   <= sop_d;
    end
  end

  // Output stage: a pop only happens when the slot is free, so a load never overwrites a pending beat.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      dsc_q    <= 1'b0;
      tkeep_q  <= '0;
      tdata_q  <= '0;
    end else begin
      if (s_axis_tx_tready) begin
        tvalid_q <= 1'b0;
      end
      if (w_load) begin
        tvalid_q <= 1'b1;
        tlast_q  <= w_marker ? 1'b1 : w_word_last;
        dsc_q    <= w_marker;
        tkeep_q  <= w_marker ? 8'hFF : dout[71:64];
        tdata_q  <= w_marker ? 64'd0 : dout[63:0];
      end
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      pkt_cnt_q  <= '0;
      dsc_cnt_q  <= '0;
      underrun_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (w_norm_done) begin
        pkt_cnt_q <= pkt_cnt_q + PKT_ONE;
      end
      if (w_pop && w_marker && (dsc_cnt_q != DSC_MAX)) begin
        dsc_cnt_q <= dsc_cnt_q + DSC_ONE;
      end
      if ((state_q == ST_XFER) && empty && w_slot_free) begin
        underrun_q <= 1'b1;
      end
      if (pkt_commit && (pend_q == PEND_MAX)) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign rd_en            = w_pop;
  assign s_axis_tx_tvalid = tvalid_q;
  assign s_axis_tx_tlast  = tlast_q;
  assign s_axis_tx_tkeep  = tkeep_q;
  assign s_axis_tx_tdata  = tdata_q;
  assign s_axis_tx_tuser  = {dsc_q, 3'b000};
  assign tx_pkt_count     = pkt_cnt_q;
  assign tx_dsc_count     = dsc_cnt_q;
  assign err_underrun     = underrun_q;
  assign err_cnt_ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tx_inject.sv
`default_nettype none
// ============================================================================
// tb_pcie_tx_inject : randomized bench with a packet-level reference model.
// Revision 1.0
// ============================================================================
module tb_pcie_tx_inject;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_commit = 1'b0;
  logic        rd_en;
  logic [73:0] dout = '0;
  logic        empty = 1'b1;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic [7:0]  tkeep;
  logic [63:0] tdata;
  logic [3:0]  tuser;
  logic [31:0] pkt_cnt;
  logic [15:0] dsc_cnt;
  logic        underrun, ovf;

  logic        s_commit = 1'b0;
  logic        s_rd_en, s_tvalid, s_tlast, s_underrun, s_ovf;
  logic [7:0]  s_tkeep;
  logic [63:0] s_tdata;
  logic [3:0]  s_tuser;
  logic [31:0] s_pkt_cnt;
  logic [15:0] s_dsc_cnt;

  always #5 clk = ~clk;

  pcie_tx_inject #(.CNT_W(8)) dut (
    .pcie_clk(clk), .pcie_rst_n(rst_n), .pkt_commit(pkt_commit), .rd_en(rd_en),
    .dout(dout), .empty(empty),
    .s_axis_tx_tvalid(tvalid), .s_axis_tx_tready(tready), .s_axis_tx_tlast(tlast),
    .s_axis_tx_tkeep(tkeep), .s_axis_tx_tdata(tdata), .s_axis_tx_tuser(tuser),
    .tx_pkt_count(pkt_cnt), .tx_dsc_count(dsc_cnt),
    .err_underrun(underrun), .err_cnt_ovf(ovf)
  );

  pcie_tx_inject #(.CNT_W(2)) u_small (
    .pcie_clk(clk), .pcie_rst_n(rst_n), .pkt_commit(s_commit), .rd_en(s_rd_en),
    .dout(74'd0), .empty(1'b1),
    .s_axis_tx_tvalid(s_tvalid), .s_axis_tx_tready(1'b1), .s_axis_tx_tlast(s_tlast),
    .s_axis_tx_tkeep(s_tkeep), .s_axis_tx_tdata(s_tdata), .s_axis_tx_tuser(s_tuser),
    .tx_pkt_count(s_pkt_cnt), .tx_dsc_count(s_dsc_cnt),
    .err_underrun(s_underrun), .err_cnt_ovf(s_ovf)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: FIFO contents, expected beats {tlast,tkeep,tdata,tuser}, counters.
  logic [73:0] fifo_q[$];
  logic [76:0] exp_beats[$];
  logic [63:0] pkt_data[$];
  int          exp_pkt = 0;
  int          exp_dsc = 0;
  int          beats_seen = 0;
  int          ready_mode = 0;
  int          pat_idx = 0;
  logic [3:0]  pat = 4'b1001;
  logic        pop_pend = 1'b0;
  logic        prev_stall = 1'b0;
  logic [76:0] prev_beat = '0;

  task automatic push_pkt(input bit trunc, input logic [7:0] last_keep);
    int n = pkt_data.size();
    for (int i = 0; i < n; i++) begin
      logic last = !trunc && (i == n - 1);
      logic [7:0] k = last ? last_keep : 8'hFF;
      fifo_q.push_back({1'b1, last, k, pkt_data[i]});
      exp_beats.push_back({last, k, pkt_data[i], 4'b0000});
    end
    if (trunc) begin
      fifo_q.push_back({1'b0, 1'b1, 8'h00, 64'd0});
      if (n > 0) exp_beats.push_back({1'b1, 8'hFF, 64'd0, 4'b1000});
      exp_dsc++;
    end else begin
      exp_pkt++;
    end
    pkt_data.delete();
  endtask

  task automatic monitor();
    logic [76:0] obs;
    if (!rst_n) begin
      pop_pend   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      obs = {tlast, tkeep, tdata, tuser};
      if (prev_stall) begin
        check_eq("hold_valid", tvalid, 1'b1);
        check_eq("hold_data", obs, prev_beat);
      end
      if (tvalid && !tready) check_eq("stall_rden", rd_en, 1'b0);
      if (tvalid && tready) begin
        beats_seen++;
        if (exp_beats.size() == 0) check_eq("extra_beat", tvalid, 1'b0);
        else check_eq("beat", obs, exp_beats.pop_front());
      end
      prev_stall = tvalid && !tready;
      prev_beat  = obs;
      pop_pend   = rd_en;
    end
  endtask

  task automatic refresh_fifo();
    empty = (fifo_q.size() == 0);
    dout  = empty ? 74'd0 : fifo_q[0];
  endtask

  // One clock cycle: check at the falling edge, update FIFO and tready just after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh_fifo();
    case (ready_mode)
      0: tready = 1'b1;
      1: begin tready = pat[pat_idx[1:0]]; pat_idx++; end
      default: tready = ($urandom_range(9, 0) < 7);
    endcase
    #1;
  endtask

  task automatic commit_pulse();
    pkt_commit = 1'b1;
    step();
    pkt_commit = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_beats.size() > 0 || fifo_q.size() > 0 || tvalid) && n < 3000) begin
      step();
      n++;
    end
    check_eq("drain_left", exp_beats.size() + fifo_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_tvalid"}, tvalid, 1'b0);
    check_eq({tag, "_rden"}, rd_en, 1'b0);
    check_eq({tag, "_beat"}, {tlast, tkeep, tdata, tuser}, 77'd0);
    check_eq({tag, "_stats"}, {pkt_cnt, dsc_cnt, underrun, ovf}, 50'd0);
  endtask

  initial begin
    int lat_rd, lat_v, bad, base;

    #1;
    check_idle_outputs("rst");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    check_idle_outputs("post_rst");
    check_eq("post_rst_pend", dut.pend_q, 8'd0);

    // Single packet with latency measurement.
    pkt_data = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333};
    push_pkt(1'b0, 8'h0F);
    step();
    pkt_commit = 1'b1;
    lat_rd = -1;
    lat_v  = -1;
    for (int c = 0; c < 12; c++) begin
      if (lat_rd < 0 && rd_en) lat_rd = c;
      if (lat_v < 0 && tvalid) lat_v = c;
      step();
      pkt_commit = 1'b0;
      if (lat_v >= 0) break;
    end
    check_eq("lat_rden", lat_rd, 2);
    check_eq("lat_tvalid", lat_v, 3);
    drain();
    check_eq("single_pkt_cnt", pkt_cnt, 32'd1);
    check_eq("single_pend", dut.pend_q, 8'd0);

    // Uncommitted words must stay in the FIFO.
    pkt_data = '{64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002};
    push_pkt(1'b0, 8'hFF);
    bad = 0;
    repeat (50) begin
      step();
      if (rd_en || tvalid) bad++;
    end
    check_eq("hold_no_rd", bad, 0);
    commit_pulse();
    drain();

    // Backpressure pattern 1,0,0,1.
    ready_mode = 1;
    pat_idx = 0;
    pkt_data = '{64'hB0B0_0000_0000_0001, 64'hB0B0_0000_0000_0002,
                 64'hB0B0_0000_0000_0003, 64'hB0B0_0000_0000_0004};
    push_pkt(1'b0, 8'h07);
    commit_pulse();
    drain();
    ready_mode = 0;
    check_eq("bp_pkt_cnt", pkt_cnt, exp_pkt);

    // Markers: truncated two-word packet, then marker-only packet.
    pkt_data = '{64'hC0C0_C0C0_0000_0001};
    push_pkt(1'b1, 8'hFF);
    commit_pulse();
    drain();
    check_eq("mk_dsc1", dsc_cnt, 16'd1);
    push_pkt(1'b1, 8'hFF);
    commit_pulse();
    drain();
    check_eq("mk_dsc2", dsc_cnt, 16'd2);
    check_eq("mk_pend", dut.pend_q, 8'd0);
    check_eq("mk_pkt_cnt", pkt_cnt, exp_pkt);

    // Commit coinciding with the tlast pop while one packet is pending.
    pkt_data = '{64'hD0D0_0000_0000_00AA};
    push_pkt(1'b0, 8'hFF);
    pkt_data = '{64'hD0D0_0000_0000_00BB, 64'hD0D0_0000_0000_00CC};
    push_pkt(1'b0, 8'h3F);
    step();
    pkt_commit = 1'b1;
    step();
    pkt_commit = 1'b0;
    step();
    pkt_commit = 1'b1;
    check_eq("edge_pop_a", rd_en, 1'b1);
    step();
    pkt_commit = 1'b0;
    check_eq("edge_pend", dut.pend_q, 8'd1);
    check_eq("edge_pop_b", rd_en, 1'b1);
    check_eq("edge_beat_a", tvalid, 1'b1);
    step();
    check_eq("edge_beat_b", tvalid, 1'b1);
    drain();

    // Saturation of a 2-bit pending counter.
    s_commit = 1'b1;
    repeat (3) step();
    check_eq("sat_pend3", u_small.pend_q, 2'd3);
    check_eq("sat_ovf0", s_ovf, 1'b0);
    step();
    s_commit = 1'b0;
    check_eq("sat_pend", u_small.pend_q, 2'd3);
    check_eq("sat_ovf1", s_ovf, 1'b1);
    check_eq("sat_underrun", s_underrun, 1'b1);
    check_eq("sat_outs", {s_rd_en, s_tvalid, s_tlast, s_tkeep, s_tdata, s_tuser}, 79'd0);
    check_eq("sat_cnts", {s_pkt_cnt, s_dsc_cnt}, 48'd0);

    // Randomized packets, commit gaps and backpressure.
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      bit trunc = ($urandom_range(5, 0) == 0);
      int n = trunc ? $urandom_range(3, 0) : $urandom_range(6, 1);
      for (int i = 0; i < n; i++) pkt_data.push_back({$urandom(), $urandom()});
      push_pkt(trunc, 8'($urandom_range(255, 1)));
      commit_pulse();
      repeat ($urandom_range(3, 0)) step();
    end
    drain();
    ready_mode = 0;
    check_eq("rnd_pkt_cnt", pkt_cnt, exp_pkt);
    check_eq("rnd_dsc_cnt", dsc_cnt, exp_dsc);
    check_eq("rnd_underrun", underrun, 1'b0);
    check_eq("rnd_ovf", ovf, 1'b0);
    check_eq("rnd_pend", dut.pend_q, 8'd0);

    // Reset in the middle of a packet.
    pkt_data = '{64'hE0E0_0000_0000_0001, 64'hE0E0_0000_0000_0002,
                 64'hE0E0_0000_0000_0003, 64'hE0E0_0000_0000_0004};
    push_pkt(1'b0, 8'hFF);
    base = beats_seen;
    commit_pulse();
    for (int c = 0; c < 20 && (beats_seen - base) < 2; c++) step();
    check_eq("mid_beats", beats_seen - base, 2);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    check_eq("mid_rst_pend", dut.pend_q, 8'd0);
    fifo_q.delete();
    exp_beats.delete();
    exp_pkt = 0;
    exp_dsc = 0;
    refresh_fifo();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    check_idle_outputs("mid_after");
    check_eq("mid_after_pend", dut.pend_q, 8'd0);
    pkt_data = '{64'hF0F0_0000_0000_0001, 64'hF0F0_0000_0000_0002};
    push_pkt(1'b0, 8'h01);
    commit_pulse();
    drain();
    check_eq("mid_after_pkt", pkt_cnt, exp_pkt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcie_tx_inject.md
# pcie_tx_inject

Consumes complete TLP packets buffered in the TX TLP FIFO, which the Ethernet decapsulation stage fills, and drives them onto the PCIe core transmit AXI4-Stream interface (64-bit, 7-series format). The block releases a packet only after the writer has committed it in full, so a slow or stalled Ethernet side can never starve the PCIe link mid-TLP. Truncation markers from the writer's FIFO-full recovery are either dropped or converted to a source-discontinue beat. The block runs entirely in the PCIe user clock domain.

## Interface

- `CNT_W`, 8: width of the pending-packet counter; must cover FIFO depth in packets.
- `pcie_clk` in 1: PCIe user clock; every register is in this domain.
- `pcie_rst_n` in 1: asynchronous, active-low reset.
- `pkt_commit` in 1: one-cycle pulse, already synchronised to `pcie_clk`; one complete packet is now in the FIFO.
- `rd_en` out 1: FIFO pop; FIFO is first-word-fall-through.
- `dout` in 74: FIFO word {tvalid, tlast, tkeep[7:0], tdata[63:0]}.
- `empty` in 1: FIFO empty.
- `s_axis_tx_tvalid` out 1, `s_axis_tx_tready` in 1, `s_axis_tx_tlast` out 1, `s_axis_tx_tkeep` out 8, `s_axis_tx_tdata` out 64: PCIe TX stream.
- `s_axis_tx_tuser` out 4: {src_dsc, str, err_fwd, ecrc_gen}.
- `tx_pkt_count` out 32: packets sent with a normal tlast; wraps.
- `tx_dsc_count` out 16: packets ended by discontinue or dropped; saturates at 16'hFFFF.
- `err_underrun` out 1: sticky; FIFO went empty inside a committed packet.
- `err_cnt_ovf` out 1: sticky; `pkt_commit` arrived while the counter was at its maximum.

## Operation

- **Pending counter `pend`.** Increment on `pkt_commit`. Decrement on the pop of any word with `dout.tlast`=1. When both happen in the same cycle, `pend` is unchanged. Saturates at 2^CNT_W-1; a commit at the maximum sets `err_cnt_ovf`. Decrement at 0 cannot occur because popping requires `pend`≠0.
- **State machine.**
  - IDLE: `rd_en`=0. If `pend`≠0, next state is XFER.
  - XFER: `rd_en` = !empty && slot_free. slot_free = !s_axis_tx_tvalid || s_axis_tx_tready. If `empty` with slot_free, set `err_underrun` and stay in XFER.
  - On a tlast pop, next state is XFER if pend_next≠0, else IDLE.
- **Output register.** Loaded on each pop, except a dropped marker. Holds while tvalid && !tready.
- **Normal word** (`dout.tvalid`=1): tdata and tkeep pass through unchanged; tlast = `dout.tlast`; tuser = 4'b0000.
- **Marker word** (`dout.tvalid`=0, `dout.tlast`=1):
  - If it is the first word of the packet (`sop` flag set), drop it. No beat is sent; `tx_dsc_count`+1.
  - Otherwise emit one beat: tdata=0, tkeep=8'hFF, tlast=1, tuser=4'b1000. `tx_dsc_count`+1.
- **`sop` flag.** Set at reset and after every tlast pop; cleared after any non-tlast pop.
- **`tx_pkt_count`.** +1 when a normal tlast beat is accepted (tvalid && tready && tlast && !tuser[3]).
- **Ordering.** Words never reorder, duplicate or skip.

## Timing

- **Reset values.** All outputs are 0 during and after reset, and state is IDLE. That covers `rd_en`, every s_axis_tx_* signal, both counters, both error flags, and `pend`=0; `sop`=1. Reset is asynchronous; deassertion is used synchronously.
- **Reset mid-packet.** The partial packet is abandoned and tvalid drops immediately. The top level resets the FIFO and the upstream stage together.
- **Latency.** `pkt_commit` at cycle N, then `pend`=1 at N+1, state XFER at N+2, `rd_en` at N+2, first `s_axis_tx_tvalid` at N+3.
- **Throughput.** One word per cycle while tready=1. Back-to-back packets have no idle cycle when `pend`≥2 at the tlast pop.
- **Stall.** When tready=0 and tvalid=1, `rd_en`=0 in that same cycle; no word is lost and no bubble is inserted beyond the stall.
- **tvalid stability.** tvalid, once asserted, stays high with stable data until accepted (AXI4-Stream rule).

## Test plan

- **Single packet.** Three words (0x1111…, 0x2222…, 0x3333… with tlast, tkeep=8'h0F) written, then `pkt_commit` at cycle 10, tready=1 → beats at cycles 13, 14, 15. Last beat has tkeep=8'h0F and tlast=1. `tx_pkt_count`=1, `pend`=0, state IDLE at 16.
- **Hold until commit.** Words present but no `pkt_commit` for 50 cycles → `rd_en` stays 0 and tvalid stays 0 throughout.
- **Backpressure.** tready toggles 1,0,0,1 over a four-word packet → every word is sent exactly once in order; tdata is stable during stalls; no `rd_en` in stalled cycles.
- **Markers.** A two-word packet whose second word is a marker → beat 2 has tuser=4'b1000 and tlast=1; `tx_dsc_count`=1. A marker-only packet → no beat; `tx_dsc_count`=2; `pend` returns to 0.
- **Counter edges.** `pkt_commit` in the same cycle as a tlast pop with `pend`=1 → `pend` stays 1 and the next packet starts with no idle cycle. With CNT_W=2, four commits with no reads → `pend`=3 and `err_cnt_ovf`=1.
- **Reset mid-packet.** `pcie_rst_n` asserted low after beat 2 of 4 → all outputs are 0 immediately (no clock edge needed); after release, state is IDLE with `pend`=0.
